stage_fetch: RTL and testbench

//  Fetch stage feeding the decode pipeline register (StageD inputs _pc/_valid plus raw instruction).

---
 rtl/stage_fetch_if.sv | 25 ++
 rtl/stage_fetch.sv | 94 +++++++++
 tb/tb_stage_fetch.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_fetch_if.sv
// Fetch-stage bundle: execute-side control, instruction-memory handshake and the
// {pc, instr, valid} head presented to the decode pipeline register.
interface stage_fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        sig_exec_lw_block;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;

  modport master (
    input  redirect, redirect_pc, sig_exec_lw_block, halt, imem_ack, imem_data,
    output imem_req, imem_addr, instr, pc, valid
  );

  modport slave (
    output redirect, redirect_pc, sig_exec_lw_block, halt, imem_ack, imem_data,
    input  imem_req, imem_addr, instr, pc, valid
  );
endinterface

// File: rtl/stage_fetch.sv
// Fetch stage: owns the PC, keeps at most one instruction-memory request in flight
// and queues {pc, instr} responses in a small FIFO ahead of decode.
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          masked_clk,
  input  logic          rst_n,
  stage_fetch_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   req_pc_r;
  logic          outstanding_r;
  logic          drop_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];

  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW-1:0] count_next_s;

  assign valid_s      = (count_r != {CW{1'b0}});
  assign pop_s        = valid_s & ~bus.sig_exec_lw_block & ~bus.redirect;
  assign push_s       = bus.imem_ack & ~drop_r & ~bus.redirect;
  assign count_next_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  // Issue only if the response is guaranteed a FIFO slot once it returns.
  assign issue_s      = ~bus.redirect & ~bus.halt & (~outstanding_r | bus.imem_ack) &
                        (count_next_s < DEPTH_C);

  assign bus.imem_req  = issue_s;
  assign bus.imem_addr = pc_r;
  assign bus.valid     = valid_s;
  assign bus.instr     = valid_s ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.pc        = valid_s ? pc_mem_r[rd_ptr_r]    : 32'h0000_0000;

  // PC, request tracking and FIFO control state.
  always_ff @(posedge masked_clk) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      req_pc_r      <= 32'h0000_0000;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else if (bus.redirect) begin
      pc_r          <= bus.redirect_pc;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      // A request still in flight now belongs to the old path; discard its ack.
      drop_r        <= outstanding_r & ~bus.imem_ack;
      outstanding_r <= outstanding_r & ~bus.imem_ack;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      if (issue_s) begin
        outstanding_r <= 1'b1;
        req_pc_r      <= pc_r;
        pc_r          <= pc_r + 32'd4;
      end else if (bus.imem_ack) begin
        outstanding_r <= 1'b0;
      end
      if (bus.imem_ack) begin
        drop_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are only meaningful below count_r, so no reset needed.
  always_ff @(posedge masked_clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= req_pc_r;
      instr_mem_r[wr_ptr_r] <= bus.imem_data;
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: variable-latency memory model, in-order scoreboard of
// consumed {pc, instr}, and directed checks on reset, stall, redirect, halt and wrap.
module tb_stage_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic masked_clk;
  logic rst_n;
  stage_fetch_if bus ();

  stage_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .masked_clk (masked_clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;
  int lat       = 1;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  logic [31:0] sb_q [$];
  logic        found;

  initial masked_clk = 1'b0;
  always #5 masked_clk = ~masked_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_reload(input logic [31:0] base);
    logic [31:0] p;
    p = base;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      sb_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic cyc();
    @(negedge masked_clk);
    #1;
  endtask

  // Memory model: accepts a request when imem_req is high, answers after lat cycles.
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    forever begin
      @(negedge masked_clk);
      bus.imem_ack  = 1'b0;
      bus.imem_data = 32'h0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
      #3;
      if (rst_n && bus.imem_req) begin
        check_eq("one_outstanding", {31'h0, pend}, 32'h0);
        pend      = 1'b1;
        pend_addr = bus.imem_addr;
        pend_cnt  = lat;
      end
    end
  end

  // Scoreboard: expected stream restarts on reset/redirect, compared on every consume.
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge masked_clk);
      #3;
      if (!rst_n) begin
        sb_reload(RST_PC);
      end else if (bus.redirect) begin
        sb_reload(bus.redirect_pc);
      end else if (bus.valid && !bus.sig_exec_lw_block) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", 32'h1, 32'h0);
        end else begin
          exp_pc = sb_q.pop_front();
          check_eq("sb_pc", bus.pc, exp_pc);
          check_eq("sb_instr", bus.instr, mem_word(exp_pc));
        end
      end
    end
  end

  initial begin
    rst_n                 = 1'b0;
    bus.redirect          = 1'b0;
    bus.redirect_pc       = 32'h0;
    bus.sig_exec_lw_block = 1'b0;
    bus.halt              = 1'b0;
    cyc();
    cyc();
    check_eq("rst_valid", {31'h0, bus.valid}, 32'h0);
    check_eq("rst_pc", bus.pc, 32'h0);
    check_eq("rst_instr", bus.instr, 32'h0);

    // Reset release and first-fetch latency
    rst_n = 1'b1;
    #1;
    check_eq("first_req", {31'h0, bus.imem_req}, 32'h1);
    check_eq("first_addr", bus.imem_addr, 32'h0000_0100);
    cyc();
    check_eq("lat_not_yet", {31'h0, bus.valid}, 32'h0);
    cyc();
    check_eq("lat_valid", {31'h0, bus.valid}, 32'h1);
    check_eq("lat_pc0", bus.pc, 32'h0000_0100);
    cyc();
    check_eq("seq_pc1", bus.pc, 32'h0000_0104);
    cyc();
    check_eq("seq_pc2", bus.pc, 32'h0000_0108);

    // Load-use stall until the FIFO fills
    bus.sig_exec_lw_block = 1'b1;
    #1;
    check_eq("stall_full_req", {31'h0, bus.imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("stall_pc", bus.pc, 32'h0000_0108);
      check_eq("stall_valid", {31'h0, bus.valid}, 32'h1);
      check_eq("stall_req", {31'h0, bus.imem_req}, 32'h0);
    end
    cyc();
    bus.sig_exec_lw_block = 1'b0;
    #1;
    check_eq("release_pc", bus.pc, 32'h0000_0108);
    check_eq("release_req", {31'h0, bus.imem_req}, 32'h1);
    check_eq("release_addr", bus.imem_addr, 32'h0000_0110);
    cyc();
    check_eq("release_pc1", bus.pc, 32'h0000_010C);
    cyc();
    check_eq("release_pc2", bus.pc, 32'h0000_0110);

    // Redirect while a slow fetch is in flight
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc();
      found = pend;
    end
    check_eq("stale_wait", {31'h0, found}, 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    cyc();
    bus.redirect = 1'b0;
    lat = 1;
    check_eq("redir_flush", {31'h0, bus.valid}, 32'h0);
    for (int i = 0; i < 12 && !bus.valid; i++) cyc();
    check_eq("redir_valid", {31'h0, bus.valid}, 32'h1);
    check_eq("redir_pc", bus.pc, 32'h0000_0400);
    check_eq("redir_instr", bus.instr, mem_word(32'h0000_0400));

    // Redirect coinciding with ack and pop
    cyc();
    cyc();
    cyc();
    check_eq("coinc_pre_valid", {31'h0, bus.valid}, 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0800;
    #1;
    check_eq("coinc_no_issue", {31'h0, bus.imem_req}, 32'h0);
    cyc();
    bus.redirect = 1'b0;
    check_eq("coinc_empty", {31'h0, bus.valid}, 32'h0);
    #1;
    check_eq("coinc_req", {31'h0, bus.imem_req}, 32'h1);
    check_eq("coinc_addr", bus.imem_addr, 32'h0000_0800);
    cyc();
    cyc();

    // PC wrap at the top of the address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check_eq("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    cyc();
    check_eq("wrap_req1", {31'h0, bus.imem_req}, 32'h1);
    check_eq("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    check_eq("wrap_req2", {31'h0, bus.imem_req}, 32'h1);
    check_eq("wrap_addr2", bus.imem_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) cyc();

    // Halt: no issue, FIFO drains; then redirect while halted
    bus.halt = 1'b1;
    #1;
    check_eq("halt_req0", {31'h0, bus.imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("halt_req", {31'h0, bus.imem_req}, 32'h0);
    end
    check_eq("halt_drained", {31'h0, bus.valid}, 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    #1;
    check_eq("rh_req", {31'h0, bus.imem_req}, 32'h0);
    cyc();
    bus.redirect = 1'b0;
    #1;
    check_eq("rh_hold_req", {31'h0, bus.imem_req}, 32'h0);
    cyc();
    bus.halt = 1'b0;
    #1;
    check_eq("rh_resume_req", {31'h0, bus.imem_req}, 32'h1);
    check_eq("rh_resume_addr", bus.imem_addr, 32'h0000_0200);
    for (int i = 0; i < 4; i++) cyc();

    // Reset mid-stream with data buffered and a fetch outstanding
    lat = 3;
    cyc();
    bus.sig_exec_lw_block = 1'b1;
    found = pend;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc();
      found = pend;
    end
    check_eq("mrst_pend", {31'h0, found}, 32'h1);
    check_eq("mrst_pre_valid", {31'h0, bus.valid}, 32'h1);
    rst_n = 1'b0;
    bus.sig_exec_lw_block = 1'b0;
    lat = 1;
    cyc();
    check_eq("mrst_valid", {31'h0, bus.valid}, 32'h0);
    check_eq("mrst_pc", bus.pc, 32'h0);
    check_eq("mrst_instr", bus.instr, 32'h0);
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 1'b1;
    #1;
    check_eq("mrst_req", {31'h0, bus.imem_req}, 32'h1);
    check_eq("mrst_addr", bus.imem_addr, RST_PC);
    cyc();
    for (int i = 0; i < 8 && !bus.valid; i++) cyc();
    check_eq("mrst_first_valid", {31'h0, bus.valid}, 32'h1);
    check_eq("mrst_first_pc", bus.pc, RST_PC);
    for (int i = 0; i < 3; i++) cyc();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
